// File: rtl/alu_result_queue.sv
// alu_result_queue: valid/ready FIFO that buffers ALU results and flags zero results at capture.
// Define ALU_RQ_STATS_EN to add a saturating carry_cnt output counting pushes with carry set.
module alu_result_queue #(
    parameter int W     = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [W-1:0]               in_result,
    input  logic                       in_carry,
    input  logic [2:0]                 in_sel,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [W-1:0]               out_result,
    output logic                       out_carry,
    output logic                       out_zero,
    output logic [2:0]                 out_sel,
    output logic [$clog2(DEPTH):0]     count,
`ifdef ALU_RQ_STATS_EN
    output logic [7:0]                 carry_cnt,
`endif
    output logic                       ovf_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = W + 5;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          w_push;
    logic          w_pop;

    // Handshake flags come only from registered occupancy, so no ready-to-ready path exists.
    assign in_ready  = r_count != FULL;
    assign out_valid = r_count != '0;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign {out_sel, out_zero, out_carry, out_result} = r_mem[r_rptr];
    assign count     = r_count;
    assign ovf_err   = r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= {in_sel, in_result == '0, in_carry, in_result};
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (in_valid && !in_ready) r_ovf <= 1'b1;
        end
    end

`ifdef ALU_RQ_STATS_EN
    logic [7:0] r_carry_cnt;
    assign carry_cnt = r_carry_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_carry_cnt <= '0;
        else if (w_push && in_carry && r_carry_cnt != 8'hFF) r_carry_cnt <= r_carry_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_alu_result_queue.sv
// tb_alu_result_queue: directed scoreboard bench for alu_result_queue.
module tb_alu_result_queue;
    localparam int W = 4;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [W-1:0] in_result = '0;
    logic in_carry = 1'b0;
    logic [2:0] in_sel = '0;
    logic out_valid;
    logic out_ready = 1'b0;
    logic [W-1:0] out_result;
    logic out_carry;
    logic out_zero;
    logic [2:0] out_sel;
    logic [CW-1:0] count;
    logic ovf_err;
`ifdef ALU_RQ_STATS_EN
    logic [7:0] carry_cnt;
`endif

    alu_result_queue #(.W(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_carry(in_carry), .in_sel(in_sel),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_carry(out_carry), .out_zero(out_zero), .out_sel(out_sel),
        .count(count),
`ifdef ALU_RQ_STATS_EN
        .carry_cnt(carry_cnt),
`endif
        .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    logic [W+4:0] cur_exp = '0;
    logic [W+4:0] exp_q[$];
    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: pops and compares on every accepted output, records every accepted input.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL pop_unexpected: got %0h expected none", {out_sel, out_zero, out_carry, out_result});
                end else begin
                    chk("pop_entry", {out_sel, out_zero, out_carry, out_result}, exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) exp_q.push_back(cur_exp);
        end
    end

    task automatic drive(input logic [3:0] r, input logic c, input logic [2:0] s, input logic z);
        in_valid = 1'b1;
        in_result = r;
        in_carry = c;
        in_sel = s;
        cur_exp = {s, z, c, r};
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        out_ready = 1'b1;
        k = 0;
        while (count != 0 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        chk(name, count, 0);
    endtask

    logic [3:0] fr [4] = '{4'h3, 4'hF, 4'h0, 4'h8};
    logic       fc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic       fz [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        #1;
        chk("rst_count", count, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_fields", {out_sel, out_zero, out_carry, out_result}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 4; i++) drive(fr[i], fc[i], 3'(i), fz[i]);
        chk("fill_count", count, 4);
        chk("fill_in_ready", in_ready, 0);
        out_ready = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            @(posedge clk); #1;
            chk("drain_count", count, i);
        end
        out_ready = 1'b0;

        drive(4'h1, 1'b0, 3'd0, 1'b0);
        drive(4'h2, 1'b1, 3'd1, 1'b0);
        drive(4'h0, 1'b1, 3'd6, 1'b1);
        drive(4'h7, 1'b0, 3'd4, 1'b0);
        chk("pre_ovf_err", ovf_err, 0);
        drive(4'h5, 1'b0, 3'd0, 1'b0);
        chk("ovf_set", ovf_err, 1);
        chk("ovf_count", count, 4);
        drain("ovf_drain_count");
        chk("ovf_sticky", ovf_err, 1);
        out_ready = 1'b0;

        drive(4'hA, 1'b0, 3'd2, 1'b0);
        drive(4'hB, 1'b1, 3'd3, 1'b0);
        drive(4'hC, 1'b0, 3'd1, 1'b0);
        chk("mid_count", count, 3);
        rst = 1'b1;
        #1;
        chk("async_rst_count", count, 0);
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_in_ready", in_ready, 1);
        chk("async_rst_ovf", ovf_err, 0);
        chk("async_rst_out_fields", {out_sel, out_zero, out_carry, out_result}, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;

        drive(4'h4, 1'b0, 3'd0, 1'b0);
        drive(4'h0, 1'b1, 3'd1, 1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(4'(i + 6), 1'(i), 3'(i), 4'(i + 6) == 4'h0);
            chk("stream_count", count, 2);
        end
        drain("stream_drain_count");

        for (int i = 0; i < 3 * DEPTH; i++) begin
            logic acc;
            int k;
            in_valid = 1'b1;
            in_result = 4'(i * 5);
            in_carry = 1'(i >> 1);
            in_sel = 3'(i);
            cur_exp = {3'(i), 4'(i * 5) == 4'h0, 1'(i >> 1), 4'(i * 5)};
            k = 0;
            do begin
                out_ready = 1'($urandom_range(0, 1));
                acc = in_ready;
                @(posedge clk); #1;
                k++;
            end while (!acc && k < 50);
            if (!acc) begin
                n_total++;
                $display("FAIL wrap_push_timeout: entry %0d not accepted", i);
            end
        end
        in_valid = 1'b0;
        drain("wrap_drain_count");
        chk("wrap_scoreboard_empty", exp_q.size(), 0);

`ifdef ALU_RQ_STATS_EN
        rst = 1'b1;
        #1;
        exp_q.delete();
        chk("stats_rst", carry_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) drive(4'(i), 1'b1, 3'd0, 4'(i) == 4'h0);
        chk("stats_saturated", carry_cnt, 255);
        drain("stats_drain_count");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/alu_result_queue.md
# alu_result_queue

Buffering stage directly downstream of the 4-bit ALU. Each cycle it can accept one ALU result (result nibble, carry, opcode) under a valid/ready handshake. It stores the result in a small FIFO, computes a zero flag at capture, and presents entries in order to the consumer (writeback/display logic) under a second valid/ready handshake. This decouples the purely combinational ALU from a consumer that may stall.

## Interface
Parameters:
- W, 4, result width; matches ALU output width
- DEPTH, 4, FIFO entries; power of two, ≥2

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  producer presents an ALU result this cycle
- in_ready  out  1  queue can accept; equals !full
- in_result  in  W  ALU result nibble
- in_carry  in  1  ALU carry/borrow flag
- in_sel  in  3  ALU opcode that produced the result
- out_valid  out  1  head entry available; equals !empty
- out_ready  in  1  consumer takes head entry this cycle
- out_result  out  W  head result
- out_carry  out  1  head carry
- out_zero  out  1  head result == 0, computed at capture
- out_sel  out  3  head opcode
- count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH
- ovf_err  out  1  sticky: push attempted while full

## Operation
- Push = in_valid && in_ready; writes {in_sel, in_zero, in_carry, in_result} at the write pointer, where in_zero = (in_result == 0).
- Pop = out_valid && out_ready; advances the read pointer.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Occupancy is tracked in count.
- count update: push only → +1; pop only → -1; both → unchanged.
- Full (count == DEPTH): in_ready=0. A simultaneous pop does not open a slot the same cycle, so there is no combinational out_ready→in_ready path.
- Empty (count == 0): out_valid=0. out_* hold stale storage contents and are don't-care. There is no fall-through; a pushed entry appears only on the next cycle.
- in_valid=1 while full: the entry is dropped and ovf_err sets; it clears only on rst.
- Opcodes are not interpreted. Values 5..7 (ALU default, result 0) are stored as-is, with out_zero=1.
- out_* are driven directly from the storage entry at the read pointer, with no extra register stage.
- Reset: pointers=0, count=0, in_ready=1, out_valid=0, ovf_err=0, out_result=0, out_carry=0, out_zero=0, out_sel=0. Storage is cleared to 0.
- Reset mid-operation discards all entries immediately, asynchronously.

## Timing
- Push-to-visible latency: 1 cycle. An entry pushed at edge N is on out_* with out_valid=1 after edge N.
- Sustained throughput: 1 push and 1 pop per cycle whenever 0 < count < DEPTH.
- in_ready and out_valid are functions of registered state only.
- rst assertion takes effect without a clock. Deassertion must be synchronous to clk; the integration level guarantees this.

## Configuration
- ALU_RQ_STATS_EN defined:
  - adds output carry_cnt [7:0].
  - carry_cnt increments on each push with in_carry=1.
  - it saturates at 255 and resets to 0 on rst.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset: assert rst mid-traffic with count=3 → immediately count=0, out_valid=0, in_ready=1, ovf_err=0, out_* = 0.
- Fill/drain order: push results 4'h3(c0), 4'hF(c1), 4'h0(c0), 4'h8(c1) with out_ready=0.
  - Expected: count=4, in_ready=0.
  - Then pop with out_ready=1: same order out; out_zero=1 only on the third entry; count decrements by 1 per cycle to 0.
- Overflow: at count=4, drive in_valid=1, in_result=4'h5 → ovf_err=1 and stays 1; entry dropped; the next four pops never show 4'h5.
- Simultaneous push/pop at count=2: count remains 2 across 10 cycles of streaming; output sequence equals input sequence with a 2-cycle offset.
- Wrap-around: stream 3×DEPTH entries with random out_ready stalls → scoreboard match; no loss or duplication.
- With ALU_RQ_STATS_EN: 300 pushes with in_carry=1 → carry_cnt=255 (saturated). Without the macro: compiles with no carry_cnt port.
